regcheck_monitor: RTL and testbench



---
 rtl/regcheck_pkg.sv | 18 +
 rtl/regcheck_table.sv | 34 +++
 rtl/regcheck_monitor.sv | 201 ++++++++++++++++++++
 tb/tb_regcheck_monitor.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regcheck_pkg.sv
// Shared types for the register-file checkpoint checker: FSM states and
// configuration-table select encodings.
package regcheck_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    WAIT_HALT,
    SCAN,
    REPORT,
    DONE
  } state_e;

  localparam logic [1:0] CFG_PC   = 2'd0;
  localparam logic [1:0] CFG_EXP  = 2'd1;
  localparam logic [1:0] CFG_MASK = 2'd2;

endpackage

// File: rtl/regcheck_table.sv
// Expected-value and don't-care mask storage, one row per checkpoint slot.
// Written through the config port, read asynchronously by the scanner.
module regcheck_table
  import regcheck_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int NCKPT = 4
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [1:0]               sel_i,
  input  logic [$clog2(NCKPT)-1:0] ckpt_i,
  input  logic [$clog2(NREG)-1:0]  reg_i,
  input  logic [XLEN-1:0]          data_i,
  input  logic [$clog2(NCKPT)-1:0] rd_ckpt_i,
  input  logic [$clog2(NREG)-1:0]  rd_reg_i,
  output logic [XLEN-1:0]          exp_o,
  output logic                     mask_o
);

  // Not reset: the tables must survive a monitor reset.
  logic [XLEN-1:0] exp_mem  [NCKPT][NREG];
  logic [NREG-1:0] mask_mem [NCKPT];

  always_ff @(posedge clk) begin
    if (we_i && sel_i == CFG_EXP)  exp_mem[ckpt_i][reg_i]  <= data_i;
    if (we_i && sel_i == CFG_MASK) mask_mem[ckpt_i][reg_i] <= data_i[0];
  end

  assign exp_o  = exp_mem[rd_ckpt_i][rd_reg_i];
  assign mask_o = mask_mem[rd_ckpt_i][rd_reg_i];

endmodule

// File: rtl/regcheck_monitor.sv
// Checkpoint checker: halts the core at programmed PCs, scans the register
// file one entry per cycle and reports mismatches against the expected table.
module regcheck_monitor
  import regcheck_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NREG         = 32,
  parameter int NCKPT        = 4,
  parameter int PC_W         = 32,
  parameter int ERR_W        = 8,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_i,
  input  logic [$clog2(NCKPT+1)-1:0] num_ckpt_i,
  input  logic [PC_W-1:0]            pc_i,
  input  logic                       halted_i,
  output logic                       halt_req_o,
  output logic [$clog2(NREG)-1:0]    rf_addr_o,
  input  logic [XLEN-1:0]            rf_data_i,
  input  logic                       cfg_we_i,
  input  logic [1:0]                 cfg_sel_i,
  input  logic [$clog2(NCKPT)-1:0]   cfg_ckpt_i,
  input  logic [$clog2(NREG)-1:0]    cfg_reg_i,
  input  logic [XLEN-1:0]            cfg_data_i,
  output logic                       mm_valid_o,
  output logic [$clog2(NREG)-1:0]    mm_reg_o,
  output logic [XLEN-1:0]            mm_exp_o,
  output logic [XLEN-1:0]            mm_act_o,
  output logic                       ckpt_done_o,
  output logic [$clog2(NCKPT)-1:0]   ckpt_idx_o,
  output logic                       ckpt_ok_o,
  output logic [ERR_W-1:0]           err_cnt_o,
  output logic                       done_o,
  output logic                       pass_o
);

  localparam int CK_W = $clog2(NCKPT);
  localparam int RG_W = $clog2(NREG);
  localparam int NC_W = $clog2(NCKPT+1);

  state_e            state_q, state_d;
  logic [CK_W-1:0]   idx_q, idx_d;
  logic [RG_W-1:0]   addr_q, addr_d;
  logic              halt_q, halt_d;
  logic              ckpt_err_q, ckpt_err_d;
  logic              mm_valid_q, mm_valid_d;
  logic [RG_W-1:0]   mm_reg_q, mm_reg_d;
  logic [XLEN-1:0]   mm_exp_q, mm_exp_d;
  logic [XLEN-1:0]   mm_act_q, mm_act_d;
  logic              ckpt_done_q, ckpt_done_d;
  logic              ckpt_ok_q, ckpt_ok_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic [PC_W-1:0]   ckpt_pc [NCKPT];
  logic [XLEN-1:0]   exp_val;
  logic              mask_bit, cfg_en, mismatch, last_ckpt;

  // Tables are only writable while the monitor is idle.
  assign cfg_en = cfg_we_i && (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (cfg_en && cfg_sel_i == CFG_PC) ckpt_pc[cfg_ckpt_i] <= cfg_data_i[PC_W-1:0];
  end

  regcheck_table #(.XLEN(XLEN), .NREG(NREG), .NCKPT(NCKPT)) u_table (
    .clk       (clk),
    .we_i      (cfg_en),
    .sel_i     (cfg_sel_i),
    .ckpt_i    (cfg_ckpt_i),
    .reg_i     (cfg_reg_i),
    .data_i    (cfg_data_i),
    .rd_ckpt_i (idx_q),
    .rd_reg_i  (addr_q),
    .exp_o     (exp_val),
    .mask_o    (mask_bit)
  );

  assign mismatch  = (state_q == SCAN) && !mask_bit && (rf_data_i != exp_val);
  assign last_ckpt = (NC_W'(idx_q) + NC_W'(1)) == num_ckpt_i;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    halt_d      = halt_q;
    ckpt_err_d  = ckpt_err_q;
    mm_valid_d  = 1'b0;
    mm_reg_d    = mm_reg_q;
    mm_exp_d    = mm_exp_q;
    mm_act_d    = mm_act_q;
    ckpt_done_d = 1'b0;
    ckpt_ok_d   = ckpt_ok_q;
    err_d       = err_q;
    done_d      = done_q;
    pass_d      = pass_q;
    case (state_q)
      IDLE: if (en_i) begin
        idx_d = '0;
        if (num_ckpt_i == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end else begin
          state_d = ARMED;
        end
      end
      ARMED: if (pc_i == ckpt_pc[idx_q]) begin
        halt_d  = 1'b1;
        state_d = WAIT_HALT;
      end
      WAIT_HALT: if (halted_i) begin
        addr_d  = '0;
        state_d = SCAN;
      end
      SCAN: begin
        if (mismatch) begin
          mm_valid_d = 1'b1;
          mm_reg_d   = addr_q;
          mm_exp_d   = exp_val;
          mm_act_d   = rf_data_i;
          ckpt_err_d = 1'b1;
          if (err_q != '1) err_d = err_q + ERR_W'(1);
        end
        if (addr_q == RG_W'(NREG-1)) begin
          // The last register's compare still counts toward this checkpoint.
          ckpt_done_d = 1'b1;
          ckpt_ok_d   = !(ckpt_err_q || mismatch);
          halt_d      = 1'b0;
          addr_d      = '0;
          state_d     = REPORT;
        end else begin
          addr_d = addr_q + RG_W'(1);
        end
      end
      REPORT: begin
        ckpt_err_d = 1'b0;
        if ((STOP_ON_FAIL && !ckpt_ok_q) || last_ckpt) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (err_q == '0);
        end else begin
          idx_d   = idx_q + CK_W'(1);
          state_d = ARMED;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      addr_q      <= '0;
      halt_q      <= 1'b0;
      ckpt_err_q  <= 1'b0;
      mm_valid_q  <= 1'b0;
      mm_reg_q    <= '0;
      mm_exp_q    <= '0;
      mm_act_q    <= '0;
      ckpt_done_q <= 1'b0;
      ckpt_ok_q   <= 1'b0;
      err_q       <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      halt_q      <= halt_d;
      ckpt_err_q  <= ckpt_err_d;
      mm_valid_q  <= mm_valid_d;
      mm_reg_q    <= mm_reg_d;
      mm_exp_q    <= mm_exp_d;
      mm_act_q    <= mm_act_d;
      ckpt_done_q <= ckpt_done_d;
      ckpt_ok_q   <= ckpt_ok_d;
      err_q       <= err_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign halt_req_o  = halt_q;
  assign rf_addr_o   = addr_q;
  assign mm_valid_o  = mm_valid_q;
  assign mm_reg_o    = mm_reg_q;
  assign mm_exp_o    = mm_exp_q;
  assign mm_act_o    = mm_act_q;
  assign ckpt_done_o = ckpt_done_q;
  assign ckpt_idx_o  = idx_q;
  assign ckpt_ok_o   = ckpt_ok_q;
  assign err_cnt_o   = err_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;

endmodule

// File: tb/tb_regcheck_monitor.sv
// Directed bench for regcheck_monitor: two instances share stimulus, one with
// stop-on-fail, against a register-file model that freezes one cycle after halt.
module tb_regcheck_monitor;
  import regcheck_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, cfg_we;
  logic [2:0]  num_ckpt;
  logic [31:0] pc, cfg_data;
  logic [1:0]  cfg_sel, cfg_ckpt;
  logic [4:0]  cfg_reg;

  logic        halt_req0, halt_req1, halted0 = 1'b0, halted1 = 1'b0;
  logic [4:0]  rf_addr0, rf_addr1, mm_reg0, mm_reg1;
  logic [31:0] rf_data0, rf_data1, mm_exp0, mm_exp1, mm_act0, mm_act1;
  logic        mm_valid0, mm_valid1, ckpt_done0, ckpt_done1, ckpt_ok0, ckpt_ok1;
  logic [1:0]  ckpt_idx0, ckpt_idx1;
  logic [7:0]  err0, err1;
  logic        done0, done1, pass0, pass1;

  logic [31:0] rf [32];
  assign rf_data0 = rf[rf_addr0];
  assign rf_data1 = rf[rf_addr1];

  always #5 clk = ~clk;
  always @(posedge clk) begin
    halted0 <= halt_req0;
    halted1 <= halt_req1;
  end

  regcheck_monitor #(.STOP_ON_FAIL(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en_i(en), .num_ckpt_i(num_ckpt), .pc_i(pc), .halted_i(halted0),
    .halt_req_o(halt_req0), .rf_addr_o(rf_addr0), .rf_data_i(rf_data0),
    .cfg_we_i(cfg_we), .cfg_sel_i(cfg_sel), .cfg_ckpt_i(cfg_ckpt), .cfg_reg_i(cfg_reg), .cfg_data_i(cfg_data),
    .mm_valid_o(mm_valid0), .mm_reg_o(mm_reg0), .mm_exp_o(mm_exp0), .mm_act_o(mm_act0),
    .ckpt_done_o(ckpt_done0), .ckpt_idx_o(ckpt_idx0), .ckpt_ok_o(ckpt_ok0),
    .err_cnt_o(err0), .done_o(done0), .pass_o(pass0));

  regcheck_monitor #(.STOP_ON_FAIL(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en_i(en), .num_ckpt_i(num_ckpt), .pc_i(pc), .halted_i(halted1),
    .halt_req_o(halt_req1), .rf_addr_o(rf_addr1), .rf_data_i(rf_data1),
    .cfg_we_i(cfg_we), .cfg_sel_i(cfg_sel), .cfg_ckpt_i(cfg_ckpt), .cfg_reg_i(cfg_reg), .cfg_data_i(cfg_data),
    .mm_valid_o(mm_valid1), .mm_reg_o(mm_reg1), .mm_exp_o(mm_exp1), .mm_act_o(mm_act1),
    .ckpt_done_o(ckpt_done1), .ckpt_idx_o(ckpt_idx1), .ckpt_ok_o(ckpt_ok1),
    .err_cnt_o(err1), .done_o(done1), .pass_o(pass1));

  int checks = 0, passes = 0;
  int mm_cnt0, mm_cnt1, done_cnt0, done_cnt1, hreq_cyc0, hrise0, hrise1;
  logic [4:0]  mm_first_reg, mm_last_reg;
  logic [31:0] mm_first_exp, mm_first_act;
  logic        ok_hist [8];
  logic [1:0]  idx_hist [8];
  logic        hr0_prev = 1'b0, hr1_prev = 1'b0;

  always @(negedge clk) begin
    if (mm_valid0) begin
      if (mm_cnt0 == 0) begin
        mm_first_reg = mm_reg0; mm_first_exp = mm_exp0; mm_first_act = mm_act0;
      end
      mm_last_reg = mm_reg0;
      mm_cnt0++;
    end
    if (mm_valid1) mm_cnt1++;
    if (ckpt_done0) begin
      if (done_cnt0 < 8) begin ok_hist[done_cnt0] = ckpt_ok0; idx_hist[done_cnt0] = ckpt_idx0; end
      done_cnt0++;
    end
    if (ckpt_done1) done_cnt1++;
    if (halt_req0) hreq_cyc0++;
    if (halt_req0 && !hr0_prev) hrise0++;
    if (halt_req1 && !hr1_prev) hrise1++;
    hr0_prev = halt_req0;
    hr1_prev = halt_req1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  function automatic logic [31:0] ev(input int r);
    return 32'h11111111 * r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cfg_wr(input logic [1:0] sel, input logic [1:0] ck, input logic [4:0] r, input logic [31:0] d);
    cfg_we = 1'b1; cfg_sel = sel; cfg_ckpt = ck; cfg_reg = r; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; pc = 32'h0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic clear_mon();
    mm_cnt0 = 0; mm_cnt1 = 0; done_cnt0 = 0; done_cnt1 = 0;
    hreq_cyc0 = 0; hrise0 = 0; hrise1 = 0;
    mm_first_reg = '0; mm_last_reg = '0; mm_first_exp = '0; mm_first_act = '0;
  endtask

  task automatic arm(input logic [2:0] n);
    num_ckpt = n; en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic present_pc(input logic [31:0] p);
    pc = p;
    tick();
    pc = 32'h0;
  endtask

  task automatic wait_ckpt(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done_cnt0 >= n) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done0) begin ok = 1'b1; break; end
      @(negedge clk); #1;
    end
  endtask

  task automatic wait_addr(input logic [4:0] a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (halted0 && halt_req0 && rf_addr0 == a) begin ok = 1'b1; break; end
    end
  endtask

  task automatic load_clean();
    for (int ck = 0; ck < 4; ck++)
      for (int r = 0; r < 32; r++) begin
        cfg_wr(CFG_EXP, 2'(ck), 5'(r), ev(r));
        cfg_wr(CFG_MASK, 2'(ck), 5'(r), 32'h0);
      end
    cfg_wr(CFG_PC, 2'd0, 5'd0, 32'h108);
    cfg_wr(CFG_PC, 2'd1, 5'd0, 32'h194);
    cfg_wr(CFG_PC, 2'd2, 5'd0, 32'h388);
    cfg_wr(CFG_PC, 2'd3, 5'd0, 32'hFFF0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if ({halt_req0, done0, pass0, mm_valid0, ckpt_done0, ckpt_ok0} !== 6'b0)
      $display("FAIL reset_flags got %b want 000000", {halt_req0, done0, pass0, mm_valid0, ckpt_done0, ckpt_ok0}); else passes++;
    checks++; if (err0 !== 8'd0) $display("FAIL reset_err got %0d want 0", err0); else passes++;
    checks++; if ({rf_addr0, ckpt_idx0, mm_reg0} !== 12'd0) $display("FAIL reset_idx got %h want 0", {rf_addr0, ckpt_idx0, mm_reg0}); else passes++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_pass();
    bit ok;
    do_reset(); clear_mon();
    arm(3'd1);
    present_pc(32'h109); present_pc(32'h1108); present_pc(32'h108);
    wait_done(ok);
    checks++; if (!ok) $display("FAIL single_done_timeout got done=%b want 1", done0); else passes++;
    checks++; if (hreq_cyc0 !== 34) $display("FAIL single_halt_cycles got %0d want 34", hreq_cyc0); else passes++;
    checks++; if (done_cnt0 !== 1 || ok_hist[0] !== 1'b1) $display("FAIL single_ckpt got cnt=%0d ok=%b want 1/1", done_cnt0, ok_hist[0]); else passes++;
    checks++; if (mm_cnt0 !== 0 || err0 !== 8'd0) $display("FAIL single_err got mm=%0d err=%0d want 0/0", mm_cnt0, err0); else passes++;
    checks++; if (pass0 !== 1'b1) $display("FAIL single_pass got %b want 1", pass0); else passes++;
  endtask

  task automatic test_mismatch();
    bit ok;
    do_reset(); clear_mon();
    rf[8] = 32'h77777777;
    arm(3'd1); present_pc(32'h108);
    wait_done(ok);
    checks++; if (!ok) $display("FAIL mm_done_timeout got done=%b want 1", done0); else passes++;
    checks++; if (mm_cnt0 !== 1 || mm_first_reg !== 5'd8) $display("FAIL mm_reg got cnt=%0d reg=%0d want 1/8", mm_cnt0, mm_first_reg); else passes++;
    checks++; if (mm_first_exp !== 32'h88888888 || mm_first_act !== 32'h77777777)
      $display("FAIL mm_data got exp=%h act=%h want 88888888/77777777", mm_first_exp, mm_first_act); else passes++;
    checks++; if (err0 !== 8'd1 || pass0 !== 1'b0 || ok_hist[0] !== 1'b0)
      $display("FAIL mm_status got err=%0d pass=%b ok=%b want 1/0/0", err0, pass0, ok_hist[0]); else passes++;
    rf[8] = ev(8);
  endtask

  task automatic test_mask();
    bit ok;
    do_reset(); clear_mon();
    cfg_wr(CFG_MASK, 2'd0, 5'd31, 32'h1);
    rf[31] = 32'hDEADBEEF;
    arm(3'd1); present_pc(32'h108);
    wait_done(ok);
    checks++; if (!ok) $display("FAIL mask_done_timeout got done=%b want 1", done0); else passes++;
    checks++; if (mm_cnt0 !== 0 || pass0 !== 1'b1 || ok_hist[0] !== 1'b1)
      $display("FAIL mask got mm=%0d pass=%b ok=%b want 0/1/1", mm_cnt0, pass0, ok_hist[0]); else passes++;
    rf[31] = ev(31);
    do_reset();
    cfg_wr(CFG_MASK, 2'd0, 5'd31, 32'h0);
  endtask

  task automatic test_multi_ckpt();
    bit ok1, ok2, ok3;
    do_reset(); clear_mon();
    cfg_wr(CFG_EXP, 2'd0, 5'd0, 32'h1);
    cfg_wr(CFG_EXP, 2'd0, 5'd31, ~ev(31));
    arm(3'd3);
    present_pc(32'h108);
    wait_ckpt(1, ok1);
    tick(); pc = 32'h194; tick(); pc = 32'h0;
    wait_ckpt(2, ok2);
    tick(); pc = 32'h388; tick(); pc = 32'h0;
    wait_done(ok3);
    repeat (3) tick();
    checks++; if (!(ok1 && ok2 && ok3)) $display("FAIL multi_timeout got %b%b%b want 111", ok1, ok2, ok3); else passes++;
    checks++; if (done_cnt0 !== 3 || {ok_hist[0], ok_hist[1], ok_hist[2]} !== 3'b011)
      $display("FAIL multi_oks got cnt=%0d oks=%b%b%b want 3/011", done_cnt0, ok_hist[0], ok_hist[1], ok_hist[2]); else passes++;
    checks++; if (idx_hist[2] !== 2'd2) $display("FAIL multi_idx got %0d want 2", idx_hist[2]); else passes++;
    checks++; if (err0 !== 8'd2 || pass0 !== 1'b0 || done0 !== 1'b1)
      $display("FAIL multi_status got err=%0d pass=%b done=%b want 2/0/1", err0, pass0, done0); else passes++;
    checks++; if (mm_first_reg !== 5'd0 || mm_last_reg !== 5'd31 || mm_first_act !== 32'h0)
      $display("FAIL multi_mm_regs got first=%0d last=%0d act=%h want 0/31/0", mm_first_reg, mm_last_reg, mm_first_act); else passes++;
    checks++; if (done_cnt1 !== 1 || hrise1 !== 1) $display("FAIL stop_halts got ckpts=%0d halts=%0d want 1/1", done_cnt1, hrise1); else passes++;
    checks++; if (done1 !== 1'b1 || err1 !== 8'd2 || pass1 !== 1'b0 || mm_cnt1 !== 2)
      $display("FAIL stop_status got done=%b err=%0d pass=%b mm=%0d want 1/2/0/2", done1, err1, pass1, mm_cnt1); else passes++;
    do_reset();
    cfg_wr(CFG_EXP, 2'd0, 5'd0, 32'h0);
    cfg_wr(CFG_EXP, 2'd0, 5'd31, ev(31));
  endtask

  task automatic test_zero_ckpt();
    do_reset(); clear_mon();
    num_ckpt = 3'd0; en = 1'b1; tick(); en = 1'b0;
    @(negedge clk); #1;
    checks++; if (done0 !== 1'b1 || pass0 !== 1'b1) $display("FAIL zero_ckpt got done=%b pass=%b want 1/1", done0, pass0); else passes++;
    arm(3'd1); present_pc(32'h108);
    repeat (5) tick();
    checks++; if (hrise0 !== 0 || done0 !== 1'b1) $display("FAIL done_sticky got halts=%0d done=%b want 0/1", hrise0, done0); else passes++;
  endtask

  task automatic test_cfg_in_scan();
    bit oka, okd;
    do_reset(); clear_mon();
    arm(3'd1); present_pc(32'h108);
    wait_addr(5'd5, oka);
    cfg_wr(CFG_EXP, 2'd0, 5'd20, 32'h00000BAD);
    wait_done(okd);
    checks++; if (!(oka && okd)) $display("FAIL scan_cfg_timeout got %b%b want 11", oka, okd); else passes++;
    checks++; if (mm_cnt0 !== 0 || pass0 !== 1'b1) $display("FAIL scan_cfg_ignored got mm=%0d pass=%b want 0/1", mm_cnt0, pass0); else passes++;
  endtask

  task automatic test_reset_mid_scan();
    bit oka, okd;
    do_reset(); clear_mon();
    rf[3] = 32'h0BADF00D;
    arm(3'd1); present_pc(32'h108);
    wait_addr(5'd10, oka);
    checks++; if (!oka || err0 !== 8'd1) $display("FAIL midscan_pre got found=%b err=%0d want 1/1", oka, err0); else passes++;
    rst = 1'b1;
    tick();
    checks++; if ({halt_req0, done0, pass0, mm_valid0, ckpt_done0} !== 5'b0)
      $display("FAIL midscan_flags got %b want 00000", {halt_req0, done0, pass0, mm_valid0, ckpt_done0}); else passes++;
    checks++; if (err0 !== 8'd0 || rf_addr0 !== 5'd0) $display("FAIL midscan_cnt got err=%0d addr=%0d want 0/0", err0, rf_addr0); else passes++;
    rst = 1'b0;
    rf[3] = ev(3);
    tick(); tick();
    clear_mon();
    arm(3'd1); present_pc(32'h108);
    wait_done(okd);
    checks++; if (!okd || hreq_cyc0 !== 34) $display("FAIL rescan got done=%b halt_cycles=%0d want 1/34", okd, hreq_cyc0); else passes++;
    checks++; if (mm_cnt0 !== 0 || pass0 !== 1'b1 || ok_hist[0] !== 1'b1)
      $display("FAIL rescan_status got mm=%0d pass=%b ok=%b want 0/1/1", mm_cnt0, pass0, ok_hist[0]); else passes++;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; pc = 32'h0; num_ckpt = 3'd0;
    cfg_we = 1'b0; cfg_sel = 2'd0; cfg_ckpt = 2'd0; cfg_reg = 5'd0; cfg_data = 32'h0;
    for (int r = 0; r < 32; r++) rf[r] = ev(r);
    clear_mon();
    test_reset();
    load_clean();
    test_single_pass();
    test_mismatch();
    test_mask();
    test_multi_ckpt();
    test_zero_ckpt();
    test_cfg_in_scan();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
